// File: rtl/apb_slave_if.sv
// ----------------------------------------------------------------------------
// apb_slave_if
// Purpose : APB3 bus bundle shared by the completer (apb_slave) and whatever
//           drives it. Clock and reset are not part of the bundle; they stay
//           plain ports on the modules that use it.
// Signals :
//   paddr   [ADDR_W-1:0] master->slave  word address
//   psel                 master->slave  slave select
//   penable              master->slave  access phase qualifier
//   pwdata  [DATA_W-1:0] master->slave  write data
//   pwrite               master->slave  1 = write, 0 = read
//   prdata  [DATA_W-1:0] slave->master  read data
//   pready               slave->master  transfer complete
//   pslverr              slave->master  error response (valid with pready)
// Modports: master, slave
// ----------------------------------------------------------------------------
interface apb_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic [DATA_W-1:0] pwdata;
  logic              pwrite;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output paddr, psel, penable, pwdata, pwrite,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwdata, pwrite,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_slave.sv
// ----------------------------------------------------------------------------
// apb_slave
// Purpose : APB3 completer in front of a DEPTH-word register memory. One
//           transfer at a time, one wait state per transfer (3 pclk cycles:
//           setup, access wait, completing cycle with pready = 1). Addresses
//           at or above DEPTH are answered with pslverr and never touch the
//           memory; reads of such addresses return 0.
// Ports   :
//   pclk     in   1           bus clock
//   presetn  in   1           asynchronous active-low reset
//   bus      slave modport    APB bundle (paddr, psel, penable, pwdata,
//                             pwrite in; prdata, pready, pslverr out)
// Parameters:
//   ADDR_W  paddr width, DATA_W data width, DEPTH memory words (paddr is a
//   word index, not byte-scaled)
// ----------------------------------------------------------------------------
module apb_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  apb_slave_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_nextState;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_prdata;
  logic              r_pready;
  logic              r_pslverr;

  logic              w_err;
  logic [IDX_W-1:0]  w_idx;
  logic              w_setupPhase;
  logic              w_accessPhase;
  logic              w_execute;

  // Any address at or beyond the memory size is an error; this also covers
  // every address with a bit set above the index bits.
  assign w_err = (bus.paddr >= ADDR_W'(DEPTH));
  assign w_idx = bus.paddr[IDX_W-1:0];

  assign w_setupPhase  = bus.psel & ~bus.penable;
  assign w_accessPhase = bus.psel &  bus.penable;

  // The transfer happens only on the SETUP->ACCESS edge; that is the single
  // point where paddr, pwdata and pwrite are sampled.
  assign w_execute = (r_state == ST_SETUP) && w_accessPhase;

  assign bus.prdata  = r_prdata;
  assign bus.pready  = r_pready;
  assign bus.pslverr = r_pslverr;

  // Next-state logic. penable seen in IDLE without a setup cycle is ignored.
  // In SETUP, a held setup phase keeps waiting; dropping psel aborts.
  // From ACCESS a master may start its next setup in the completing cycle.
  always_comb begin
    w_nextState = ST_IDLE;
    case (r_state)
      ST_IDLE: begin
        if (w_setupPhase) w_nextState = ST_SETUP;
        else              w_nextState = ST_IDLE;
      end
      ST_SETUP: begin
        if (!bus.psel)          w_nextState = ST_IDLE;
        else if (bus.penable)   w_nextState = ST_ACCESS;
        else                    w_nextState = ST_SETUP;
      end
      ST_ACCESS: begin
        if (w_setupPhase) w_nextState = ST_SETUP;
        else              w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // State register and the registered response. pready/pslverr rise together
  // on the executing edge and fall on the following edge, giving a one-cycle
  // pulse. prdata only changes on reads, so a write leaves it holding its
  // previous value.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state   <= ST_IDLE;
      r_prdata  <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
    end else begin
      r_state <= w_nextState;
      if (w_execute) begin
        r_pready  <= 1'b1;
        r_pslverr <= w_err;
        if (!bus.pwrite) begin
          r_prdata <= w_err ? '0 : r_mem[w_idx];
        end
      end else if (r_state == ST_ACCESS) begin
        r_pready  <= 1'b0;
        r_pslverr <= 1'b0;
      end
    end
  end

  // Register memory. Reset clears every word, so an unwritten location reads
  // back as zero. Erroring writes are dropped so out-of-range addresses can
  // never alias onto a valid word through the truncated index.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_execute && bus.pwrite && !w_err) begin
      r_mem[w_idx] <= bus.pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slave.sv
// ----------------------------------------------------------------------------
// tb_apb_slave
// Purpose : Self-checking bench for apb_slave. A behavioural model (array of
//           words plus the last read value) predicts every response; the
//           directed cases cover reset, write/read, address boundaries,
//           back-to-back transfers, aborted setups, stray penable and reset
//           in the middle of a transfer, followed by random transfers.
// ----------------------------------------------------------------------------
module tb_apb_slave;

  logic pclk;
  logic presetn;

  apb_slave_if #(.ADDR_W(32), .DATA_W(32)) apbBus ();

  apb_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (apbBus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [31:0] model [16];
  logic [31:0] lastPrdata;

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // Single comparison point: counts the check and reports any difference.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Clear the model to match what reset does to the design.
  task automatic resetModel();
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    lastPrdata = 32'h0;
  endtask

  // One full APB transfer, called one time unit after a rising edge.
  // With backToBack set the bus is left in the access phase so the caller
  // can issue the next setup during the completing cycle.
  task automatic applyStimulus(input bit isWrite, input logic [31:0] addr,
                               input logic [31:0] data, input bit backToBack,
                               input string tag);
    logic        expErr;
    logic [31:0] expData;
    int          edges;
    expErr  = (addr >= 32'd16);
    if (isWrite)     expData = lastPrdata;
    else if (expErr) expData = 32'h0;
    else             expData = model[addr % 16];

    apbBus.psel    = 1'b1;
    apbBus.penable = 1'b0;
    apbBus.paddr   = addr;
    apbBus.pwrite  = isWrite;
    apbBus.pwdata  = data;
    @(posedge pclk); #1;
    checkOutput({tag, "/waitReady"}, {31'h0, apbBus.pready}, 32'h0);

    apbBus.penable = 1'b1;
    edges = 1;
    do begin
      @(posedge pclk); #1;
      edges++;
    end while (!apbBus.pready && edges < 8);

    checkOutput({tag, "/cycles"}, 32'(edges + 1), 32'd3);
    checkOutput({tag, "/pslverr"}, {31'h0, apbBus.pslverr}, {31'h0, expErr});
    checkOutput({tag, "/prdata"}, apbBus.prdata, expData);

    if (isWrite && !expErr) model[addr % 16] = data;
    lastPrdata = expData;

    if (!backToBack) begin
      apbBus.psel    = 1'b0;
      apbBus.penable = 1'b0;
      @(posedge pclk); #1;
      checkOutput({tag, "/readyPulse"}, {31'h0, apbBus.pready}, 32'h0);
      checkOutput({tag, "/errClear"}, {31'h0, apbBus.pslverr}, 32'h0);
    end
  endtask

  initial begin
    bit          rndWrite;
    logic [31:0] rndAddr;
    apbBus.psel    = 1'b0;
    apbBus.penable = 1'b0;
    apbBus.paddr   = 32'h0;
    apbBus.pwrite  = 1'b0;
    apbBus.pwdata  = 32'h0;
    presetn        = 1'b0;
    resetModel();

    // Reset held for two cycles.
    repeat (2) @(posedge pclk);
    #1;
    checkOutput("reset/prdata", apbBus.prdata, 32'h0);
    checkOutput("reset/pready", {31'h0, apbBus.pready}, 32'h0);
    checkOutput("reset/pslverr", {31'h0, apbBus.pslverr}, 32'h0);
    presetn = 1'b1;
    @(posedge pclk); #1;

    applyStimulus(1'b0, 32'd5, 32'h0, 1'b0, "readUnwritten5");

    // Write then read.
    applyStimulus(1'b1, 32'd3, 32'hDEADBEEF, 1'b0, "write3");
    applyStimulus(1'b0, 32'd3, 32'h0, 1'b0, "read3");

    // Boundary addresses; addr 16 must not alias onto word 0.
    applyStimulus(1'b1, 32'd15, 32'h1, 1'b0, "write15");
    applyStimulus(1'b0, 32'd15, 32'h0, 1'b0, "read15");
    applyStimulus(1'b1, 32'd16, 32'hCAFEF00D, 1'b0, "write16");
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b0, "read0AfterWrite16");
    applyStimulus(1'b0, 32'd16, 32'h0, 1'b0, "read16");
    applyStimulus(1'b0, 32'h8000_0003, 32'h0, 1'b0, "readHighBit");

    // Back-to-back: next setup issued during the completing cycle.
    applyStimulus(1'b1, 32'd0, 32'hA5, 1'b1, "b2bWrite0");
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b0, "b2bRead0");

    // Aborted setup: psel drops before penable, nothing is written.
    apbBus.psel    = 1'b1;
    apbBus.penable = 1'b0;
    apbBus.paddr   = 32'd7;
    apbBus.pwrite  = 1'b1;
    apbBus.pwdata  = 32'h1234_5678;
    @(posedge pclk); #1;
    apbBus.psel = 1'b0;
    @(posedge pclk); #1;
    checkOutput("abort/pready", {31'h0, apbBus.pready}, 32'h0);
    applyStimulus(1'b0, 32'd7, 32'h0, 1'b0, "abortRead7");

    // penable without a setup cycle is ignored.
    apbBus.psel    = 1'b1;
    apbBus.penable = 1'b1;
    apbBus.paddr   = 32'd9;
    apbBus.pwrite  = 1'b1;
    apbBus.pwdata  = 32'h0BAD_0BAD;
    repeat (2) begin
      @(posedge pclk); #1;
      checkOutput("strayEnable/pready", {31'h0, apbBus.pready}, 32'h0);
    end
    apbBus.psel    = 1'b0;
    apbBus.penable = 1'b0;
    @(posedge pclk); #1;
    applyStimulus(1'b0, 32'd9, 32'h0, 1'b0, "strayEnableRead9");

    // Random transfers against the model.
    for (int n = 0; n < 20; n++) begin
      rndWrite = 1'($urandom_range(0, 1));
      rndAddr  = 32'($urandom_range(0, 31));
      applyStimulus(rndWrite, rndAddr, $urandom, 1'($urandom_range(0, 1)),
                    $sformatf("rand%0d", n));
    end
    apbBus.psel    = 1'b0;
    apbBus.penable = 1'b0;
    @(posedge pclk); #1;

    // Reset in the completing cycle of a read of a non-zero word.
    applyStimulus(1'b1, 32'd2, 32'h5555_AAAA, 1'b0, "preResetWrite2");
    apbBus.psel    = 1'b1;
    apbBus.penable = 1'b0;
    apbBus.paddr   = 32'd2;
    apbBus.pwrite  = 1'b0;
    @(posedge pclk); #1;
    apbBus.penable = 1'b1;
    @(posedge pclk); #1;
    checkOutput("midReset/preReady", {31'h0, apbBus.pready}, 32'h1);
    checkOutput("midReset/preData", apbBus.prdata, 32'h5555_AAAA);
    #2;
    presetn = 1'b0;
    #1;
    checkOutput("midReset/pready", {31'h0, apbBus.pready}, 32'h0);
    checkOutput("midReset/prdata", apbBus.prdata, 32'h0);
    resetModel();
    apbBus.psel    = 1'b0;
    apbBus.penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    @(posedge pclk); #1;
    applyStimulus(1'b0, 32'd2, 32'h0, 1'b0, "postResetRead2");
    applyStimulus(1'b0, 32'd3, 32'h0, 1'b0, "postResetRead3");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
